// File: rtl/vote_pkg.sv
// Shared types and one-hot vote-count encodings for the vote tally receiver.
package vote_pkg;

    typedef enum logic [1:0] {IDLE, OPEN, FINAL, DONE} state_e;

    localparam logic [3:0] R_ZERO  = 4'b0001;
    localparam logic [3:0] R_ONE   = 4'b0010;
    localparam logic [3:0] R_TWO   = 4'b0100;
    localparam logic [3:0] R_THREE = 4'b1000;

    function automatic logic onehot_legal(input logic [3:0] r);
        return (r == R_ZERO) || (r == R_ONE) || (r == R_TWO) || (r == R_THREE);
    endfunction

endpackage

// File: rtl/vote_onehot_dec.sv
// Combinational decode of a one-hot R word into a 2-bit vote count plus legality.
module vote_onehot_dec
    import vote_pkg::*;
(
    input  logic [3:0] r_i,
    output logic [1:0] count_o,
    output logic       legal_o
);

    always_comb begin
        count_o = 2'd0;
        case (r_i)
            R_ONE:   count_o = 2'd1;
            R_TWO:   count_o = 2'd2;
            R_THREE: count_o = 2'd3;
            default: count_o = 2'd0;
        endcase
        legal_o = onehot_legal(r_i);
    end

endmodule

// File: rtl/vote_tally.sv
// Session FSM, valid/ready handshake and saturating statistics for the R vote bus.
module vote_tally
    import vote_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int SUM_W = CNT_W + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             close_i,
    input  logic             r_valid_i,
    input  logic [3:0]       r_i,
    output logic             r_ready_o,
    output logic [CNT_W-1:0] rounds_o,
    output logic [SUM_W-1:0] yes_sum_o,
    output logic [CNT_W-1:0] maj_rounds_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rounds_q, rounds_d, maj_q, maj_d, err_q, err_d;
    logic [SUM_W-1:0] yes_q, yes_d;
    logic             ovf_q, ovf_d, pass_q, pass_d;
    logic [1:0]       cnt;
    logic             legal, accept, clr;

    vote_onehot_dec u_dec (
        .r_i     (r_i),
        .count_o (cnt),
        .legal_o (legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = OPEN;
            OPEN:    if (close_i) state_d = FINAL;
            FINAL:   state_d = DONE;
            DONE:    if (start_i) state_d = OPEN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_ready_o = (state_q == OPEN);
        busy_o    = (state_q == OPEN);
        done_o    = (state_q == DONE);
    end

    assign clr    = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign accept = r_valid_i && r_ready_o;

    always_comb begin
        rounds_d = rounds_q;
        yes_d    = yes_q;
        maj_d    = maj_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        pass_d   = pass_q;
        if (clr) begin
            rounds_d = '0;
            yes_d    = '0;
            maj_d    = '0;
            err_d    = '0;
            ovf_d    = 1'b0;
            pass_d   = 1'b0;
        end else begin
            if (accept) begin
                if (legal) begin
                    // A saturated round count drops the whole beat so the stats stay consistent.
                    if (&rounds_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        rounds_d = rounds_q + CNT_W'(1);
                        yes_d    = yes_q + SUM_W'(cnt);
                        if (cnt[1]) maj_d = maj_q + CNT_W'(1);
                    end
                end else if (!(&err_q)) begin
                    err_d = err_q + CNT_W'(1);
                end
            end
            if (state_q == FINAL) pass_d = {maj_q, 1'b0} > {1'b0, rounds_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rounds_q <= '0;
            yes_q    <= '0;
            maj_q    <= '0;
            err_q    <= '0;
            ovf_q    <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            rounds_q <= rounds_d;
            yes_q    <= yes_d;
            maj_q    <= maj_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            pass_q   <= pass_d;
        end
    end

    assign rounds_o     = rounds_q;
    assign yes_sum_o    = yes_q;
    assign maj_rounds_o = maj_q;
    assign err_cnt_o    = err_q;
    assign ovf_o        = ovf_q;
    assign pass_o       = pass_q;

endmodule
